// File: rtl/instr_encoder.sv
// Instruction encoder/loader: encodes symbolic instructions into 32-bit words,
// buffers them in a small FIFO and writes them sequentially into instruction memory.
module instr_encoder #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              imem_stall,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   instr_count,
  output logic              done,
  output logic              illegal_err,
  output logic              wrap_err
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ICW   = ADDR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [31:0]       fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_idx;
  logic [PTR_W-1:0]  rd_idx;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W-1:0]  fifo_cnt_d;
  logic [ADDR_W-1:0] wptr;
  logic              in_ready_d;
  logic [31:0]       enc_word_c;
  logic              op_legal_c;
  logic              accept_c;
  logic              push_c;
  logic              pop_c;

  // Combinational encode of the request currently on the input
  always_comb begin
    enc_word_c = 32'h0;
    op_legal_c = 1'b1;
    case (in_op)
      4'd0:    enc_word_c = {6'b100000, in_rs, in_rt, in_rd, 11'b0};
      4'd1:    enc_word_c = {6'b100011, in_rs, in_rt, in_imm};
      4'd2:    enc_word_c = {6'b101011, in_rs, in_rt, in_imm};
      4'd3:    enc_word_c = {6'b001000, in_rs, 21'b0};
      4'd4:    enc_word_c = {6'b000011, in_target};
      4'd5:    enc_word_c = {6'b100110, in_rs, in_rt, in_rd, 11'b0};
      4'd6:    enc_word_c = {6'b001110, in_rs, in_rt, in_imm};
      4'd7:    enc_word_c = {6'b000100, in_rs, 5'b0, in_rd, 11'b0};
      4'd8:    enc_word_c = {6'b010000, in_rs, in_rt, in_imm};
      4'd9:    enc_word_c = {6'b000000, in_rs, in_rt, in_rd, 11'b0};
      4'd10:   enc_word_c = {6'b000010, in_rs, in_rt, in_rd, 11'b0};
      default: op_legal_c = 1'b0;
    endcase
  end

  // A start in the same cycle wins over any handshake or write
  always_comb begin
    accept_c = in_valid && in_ready && !start;
    push_c   = accept_c && op_legal_c;
    pop_c    = !start && ((state_q == S_RUN) || (state_q == S_DRAIN)) &&
               (fifo_cnt != '0) && !imem_stall;
  end

  // Next state plus next values of the registered handshake/status outputs
  always_comb begin
    state_d    = state_q;
    fifo_cnt_d = fifo_cnt;
    if (start) begin
      state_d    = S_RUN;
      fifo_cnt_d = '0;
    end else begin
      fifo_cnt_d = fifo_cnt + CNT_W'(push_c) - CNT_W'(pop_c);
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_RUN:   if (finish) state_d = S_DRAIN;
        S_DRAIN: if ((fifo_cnt == '0) && !imem_we) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    in_ready_d = (state_d == S_RUN) && (fifo_cnt_d != CNT_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      in_ready <= 1'b0;
      done     <= 1'b0;
      fifo_cnt <= '0;
    end else begin
      state_q  <= state_d;
      in_ready <= in_ready_d;
      done     <= (state_d == S_DONE);
      fifo_cnt <= fifo_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) fifo_mem[wr_idx] <= enc_word_c;
  end

  // FIFO pointers, memory write port and sticky status
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx      <= '0;
      rd_idx      <= '0;
      wptr        <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      instr_count <= '0;
      illegal_err <= 1'b0;
      wrap_err    <= 1'b0;
    end else begin
      imem_we <= pop_c;
      if (start) begin
        wr_idx      <= '0;
        rd_idx      <= '0;
        wptr        <= base_addr;
        instr_count <= '0;
        illegal_err <= 1'b0;
        wrap_err    <= 1'b0;
      end else begin
        if (push_c) wr_idx <= wr_idx + PTR_W'(1);
        if (accept_c && !op_legal_c) illegal_err <= 1'b1;
        if (pop_c) begin
          rd_idx     <= rd_idx + PTR_W'(1);
          imem_addr  <= wptr;
          imem_wdata <= fifo_mem[rd_idx];
          wptr       <= wptr + ADDR_W'(1);
          if (instr_count != '1) instr_count <= instr_count + ICW'(1);
          if (wptr == '1) wrap_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized self-checking bench for instr_encoder against a queue-based reference model.
module tb_instr_encoder;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset, start, finish, in_valid, imem_stall;
  logic [ADDR_W-1:0] base_addr;
  logic              in_ready, imem_we, done, illegal_err, wrap_err;
  logic [3:0]        in_op;
  logic [4:0]        in_rs, in_rt, in_rd;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   instr_count;

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target), .imem_stall(imem_stall),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .instr_count(instr_count), .done(done), .illegal_err(illegal_err), .wrap_err(wrap_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [31:0]       exp_data_q[$];
  logic [ADDR_W-1:0] m_ptr;
  int unsigned       m_count;
  bit                m_ill, m_wrap;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference encoding from opcode table and field layout, using plain arithmetic
  function automatic logic [31:0] ref_enc(input int unsigned op, input int unsigned rs,
                                          input int unsigned rt, input int unsigned rd,
                                          input int unsigned imm, input int unsigned tgt);
    int unsigned opc [11];
    longint unsigned w;
    opc = '{32, 35, 43, 8, 3, 38, 14, 4, 16, 0, 2};
    w = longint'(opc[op]) * 64'd67108864;
    if (op inside {0, 5, 9, 10})  w += rs * 2097152 + rt * 65536 + rd * 2048;
    else if (op == 7)             w += rs * 2097152 + rd * 2048;
    else if (op inside {1, 2, 6, 8}) w += rs * 2097152 + rt * 65536 + imm;
    else if (op == 3)             w += rs * 2097152;
    else                          w += tgt;
    return 32'(w);
  endfunction

  // Write monitor: every strobe must match the next expected word in order
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (imem_we) begin
      if (exp_data_q.size() == 0) begin
        check("spurious_we", 64'(imem_we), 64'd0);
      end else begin
        check("wr_addr", 64'(imem_addr), 64'(exp_addr_q.pop_front()));
        check("wr_data", 64'(imem_wdata), 64'(exp_data_q.pop_front()));
        if (m_count < 2047) m_count++;
        check("wr_count", 64'(instr_count), 64'(m_count));
      end
    end
  end

  task automatic do_start(input logic [ADDR_W-1:0] base);
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    @(posedge clk);
    #1 start = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    m_ptr = base;
    m_count = 0;
    m_ill = 1'b0;
    m_wrap = 1'b0;
    done_cnt = 0;
  endtask

  task automatic do_finish();
    @(negedge clk);
    finish = 1'b1;
    @(posedge clk);
    #1 finish = 1'b0;
  endtask

  task automatic push(input int unsigned op, input int unsigned rs, input int unsigned rt,
                      input int unsigned rd, input int unsigned imm, input int unsigned tgt,
                      input bit rstall);
    int n = 0;
    @(negedge clk);
    in_op = 4'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_imm = 16'(imm); in_target = 26'(tgt);
    in_valid = 1'b1;
    if (rstall) imem_stall = ($urandom_range(0, 2) == 0);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      if (rstall) imem_stall = ($urandom_range(0, 2) == 0);
      n++;
    end
    if (!in_ready) begin
      check("push_timeout", 64'(in_ready), 64'd1);
    end else if (op <= 10) begin
      exp_addr_q.push_back(m_ptr);
      exp_data_q.push_back(ref_enc(op, rs, rt, rd, imm, tgt));
      if (m_ptr == '1) m_wrap = 1'b1;
      m_ptr = m_ptr + ADDR_W'(1);
    end else begin
      m_ill = 1'b1;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit rstall);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 3000) begin
      @(negedge clk);
      imem_stall = rstall ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (done) seen = 1'b1;
      n++;
    end
    imem_stall = 1'b0;
    check("done_seen", 64'(seen), 64'd1);
    repeat (3) @(negedge clk);
    check("done_once", 64'(done_cnt), 64'd1);
    check("drained", 64'(exp_data_q.size()), 64'd0);
    check("idle_ready", 64'(in_ready), 64'd0);
    check("final_count", 64'(instr_count), 64'(m_count));
    check("illegal_err", 64'(illegal_err), 64'(m_ill));
    check("wrap_err", 64'(wrap_err), 64'(m_wrap));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0; imem_stall = 1'b0;
    base_addr = '0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
    m_ptr = '0; m_count = 0; m_ill = 1'b0; m_wrap = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 64'({in_ready, imem_we, imem_addr, imem_wdata, instr_count, done,
                              illegal_err, wrap_err}), 64'd0);
    reset = 1'b0;

    // First word and its latency
    do_start(10'h010);
    check("ready_after_start", 64'(in_ready), 64'd1);
    push(1, 2, 5, 0, 16'h0004, 0, 1'b0);
    @(negedge clk);
    check("lat_no_we", 64'(imem_we), 64'd0);
    @(negedge clk);
    check("lat_we", 64'(imem_we), 64'd1);
    check("lw_word", 64'(imem_wdata), 64'h8C450004);
    check("lw_addr", 64'(imem_addr), 64'h010);
    check("lw_count", 64'(instr_count), 64'd1);
    do_finish();
    wait_done(1'b0);

    // R-type and jal then drain
    do_start(10'h010);
    push(0, 1, 2, 3, 0, 0, 1'b0);
    push(4, 0, 0, 0, 0, 26'h0000040, 1'b0);
    do_finish();
    wait_done(1'b0);

    // Back-pressure: fill FIFO under stall, fifth request waits
    do_start(10'h100);
    imem_stall = 1'b1;
    for (int i = 0; i < 4; i++) push(6, i, i + 1, 0, 16'h1000 + i, 0, 1'b0);
    @(negedge clk);
    check("full_not_ready", 64'(in_ready), 64'd0);
    check("stall_no_we", 64'(imem_we), 64'd0);
    fork
      push(8, 7, 9, 0, 16'hBEEF, 0, 1'b0);
      begin
        repeat (3) @(negedge clk);
        check("still_full", 64'(in_ready), 64'd0);
        imem_stall = 1'b0;
      end
    join
    do_finish();
    wait_done(1'b0);

    // Illegal op, then a new start clears the flag
    do_start(10'h040);
    push(12, 1, 1, 1, 1, 1, 1'b0);
    repeat (3) @(negedge clk);
    check("illegal_set", 64'(illegal_err), 64'd1);
    do_finish();
    wait_done(1'b0);
    do_start(10'h040);
    @(negedge clk);
    check("illegal_cleared", 64'(illegal_err), 64'd0);
    do_finish();
    wait_done(1'b0);

    // Address wrap at top of memory
    do_start(10'h3FE);
    for (int i = 0; i < 3; i++) push(6, 0, 1, 0, 16'hFFFF, 0, 1'b0);
    do_finish();
    wait_done(1'b0);

    // Reset while draining with words still queued
    do_start(10'h020);
    imem_stall = 1'b1;
    push(2, 3, 4, 0, 16'h0008, 0, 1'b0);
    push(3, 31, 0, 0, 0, 0, 1'b0);
    do_finish();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_addr_q.delete();
    exp_data_q.delete();
    @(negedge clk);
    check("reset_in_drain", 64'({in_ready, imem_we, imem_addr, imem_wdata, instr_count, done,
                                 illegal_err, wrap_err}), 64'd0);
    reset = 1'b0;
    imem_stall = 1'b0;
    repeat (6) @(negedge clk);
    check("reset_idle", 64'({in_ready, done}), 64'd0);

    // Randomized sessions with random stalls and occasional illegal ops
    for (int s = 0; s < 6; s++) begin
      do_start(ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1)));
      for (int k = 0; k < 30; k++) begin
        int unsigned op;
        op = ($urandom_range(0, 9) == 0) ? $urandom_range(11, 15) : $urandom_range(0, 10);
        push(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 65535), $urandom_range(0, (1 << 26) - 1), 1'b1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      do_finish();
      wait_done(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Encoder/loader that is the write-side counterpart of the instruction decoder. It accepts symbolic instructions (operation select plus register, immediate and target fields) over a valid/ready handshake. Each instruction is encoded into the 32-bit word format the decoder consumes, buffered in a small FIFO, and written sequentially into instruction memory starting at a programmable base address.

Parameters:
ADDR_W, 10, instruction-memory word-address width
DEPTH, 4, encoded-word FIFO depth (power of two, >=2)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  pulse; loads base_addr, clears counters and errors, enters RUN
finish  input  1  pulse; no more input, drain FIFO then signal done
base_addr  input  ADDR_W  first word address written after start
in_valid  input  1  instruction request valid
in_ready  output  1  encoder can accept request
in_op  input  4  op select: 0 andr,1 lw,2 sw,3 jr,4 jal,5 norr,6 nori,7 notr,8 bleu,9 rolv,10 rorv; 11-15 illegal
in_rs  input  5  source register
in_rt  input  5  second source / I-type destination
in_rd  input  5  R-type destination
in_imm  input  16  immediate / branch offset
in_target  input  26  jal target
imem_stall  input  1  memory busy; hold write
imem_we  output  1  write strobe
imem_addr  output  ADDR_W  write address
imem_wdata  output  32  encoded word
instr_count  output  ADDR_W+1  words written since start
done  output  1  one-cycle pulse after drain completes
illegal_err  output  1  sticky: illegal op received
wrap_err  output  1  sticky: address wrapped past max

Behaviour:
- Reset: state IDLE, FIFO empty, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, instr_count=0, done=0, illegal_err=0, wrap_err=0. Reset mid-operation discards FIFO contents and any pending write.
- Opcodes (ins[31:26]): andr 100000, lw 100011, sw 101011, jr 001000, jal 000011, norr 100110, nori 001110, notr 000100, bleu 010000, rolv 000000, rorv 000010.
- R-type (andr, norr, rolv, rorv): {op, rs, rt, rd, 11'b0}.
- notr: {op, rs, 5'b0, rd, 11'b0}; in_rt is ignored.
- I-type (lw, sw, nori, bleu): {op, rs, rt, imm}.
- jr: {op, rs, 21'b0}.
- jal: {op, target}.
- Unused input fields are ignored; encoding is combinational at the input and registered into the FIFO on acceptance.
- FSM states and transitions:
  - IDLE -> RUN on start.
  - RUN -> DRAIN on finish.
  - DRAIN -> DONE when FIFO is empty and no write is in flight.
  - DONE -> IDLE unconditionally; done=1 only in DONE.
  - start in any non-IDLE state behaves as reset-of-session: flush FIFO, load base_addr, clear instr_count and errors, go to RUN.
  - finish outside RUN is ignored.
- Handshake: in_ready = (state==RUN) && !fifo_full. A transfer occurs on in_valid && in_ready. in_ready does not depend combinationally on in_valid. While in_valid=1 and in_ready=0 the producer holds all inputs stable.
- Illegal op: the handshake completes but nothing is enqueued; illegal_err=1 from the next cycle.
- Write port:
  - When the FIFO is non-empty and imem_stall=0 (RUN or DRAIN), pop the head and register imem_we=1, imem_wdata=head, imem_addr=current pointer.
  - Then the pointer and instr_count increment.
  - Latency: a request accepted at edge N produces imem_we=1 at edge N+1 at the earliest.
  - While imem_stall=1: imem_we=0, no pop, pointer held.
- Simultaneous push and pop in the same cycle are allowed; occupancy is unchanged. Full is evaluated before the pop, so there is no accept-on-full.
- Wrap: the pointer increments modulo 2^ADDR_W. A write at address 2^ADDR_W-1 sets wrap_err sticky and writing continues at address 0.
- instr_count saturates at 2^(ADDR_W+1)-1.

Test Plan:
- Reset, then start with base_addr=0x010; push lw rs=2 rt=5 imm=0x0004 -> imem_we at addr 0x010, wdata=0x8C450004, instr_count=1.
- Push andr rs=1 rt=2 rd=3, then jal target=0x0000040, then finish -> writes 0x80221800 @0x010 and 0x0C000040 @0x011; done pulses once; state returns to IDLE.
- Hold imem_stall=1 and push 5 valid ops with DEPTH=4 -> 4 accepted, then in_ready=0; release stall -> all 4 written in order, 5th accepted, no loss or duplication.
- in_op=12 with in_valid=1 -> handshake completes, no imem_we, illegal_err=1; next start clears it.
- ADDR_W=4, base_addr=0xE, push 3 nori rs=0 rt=1 imm=0xFFFF -> writes 0x3801FFFF at 0xE, 0xF, 0x0; wrap_err=1.
- Assert reset in DRAIN with 2 words queued -> no further imem_we, all outputs return to reset values on the next cycle.
